// File: rtl/ext_input_buffer.sv
// Show-ahead FIFO feeding the external-input operand path of the B-operand mux.
// Producer side uses valid/ready; consumer pops the head word with a one-cycle strobe.
module ext_input_buffer #(
   parameter int unsigned DATA_WIDTH = 11,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         read_ext,
   input  logic                         clear_error,
   output logic [DATA_WIDTH-1:0]        ext_out,
   output logic                         ext_available,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         underflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]       wptr_q, wptr_d;
   logic [PtrW-1:0]       rptr_q, rptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  underflow_q, underflow_d;

   logic not_empty;
   logic push;
   logic pop;
   logic underflow_evt;

   assign not_empty     = (count_q != '0);
   assign in_ready      = (count_q != CntW'(DEPTH));
   assign push          = in_valid && in_ready;
   assign pop           = read_ext && not_empty;
   assign underflow_evt = read_ext && !not_empty;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      underflow_d = underflow_q;

      if (push) begin
         wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      // A new underflow on the same edge as a clear keeps the flag set.
      if (underflow_evt) begin
         underflow_d = 1'b1;
      end else if (clear_error) begin
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage needs no reset: ext_out is masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= in_data;
      end
   end

   assign ext_out       = not_empty ? mem_q[rptr_q] : '0;
   assign ext_available = not_empty;
   assign count         = count_q;
   assign underflow     = underflow_q;

endmodule

// File: doc/ext_input_buffer.md
Name: ext_input_buffer

Overview:
- Show-ahead FIFO between the external input pins and the mux_2x1 `in_1` operand path (B-operand select).
- External producer writes words with a valid/ready handshake.
- The datapath reads the head word on `ext_out` and pops it with a one-cycle `read_ext` strobe when an input instruction retires.
- Decouples external timing from instruction timing.

Parameters:
- DATA_WIDTH, 11, word width; matches the datapath/mux width.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  word from the external producer.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- read_ext  input  1  pop strobe from control; one cycle per consumed word.
- clear_error  input  1  synchronous clear of the sticky underflow flag.
- ext_out  output  DATA_WIDTH  head word; drives mux_2x1 in_1.
- ext_available  output  1  buffer non-empty.
- count  output  $clog2(DEPTH+1)  current occupancy.
- underflow  output  1  sticky: read_ext was seen while empty.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Pointers = 0, count = 0, underflow = 0.
  - Storage contents are don't-care; outputs: ext_available = 0, ext_out = 0, in_ready = 1.
- Storage: DEPTH-entry register array, write pointer and read pointer of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH (natural overflow). Occupancy is tracked by a separate count register.
- Push: occurs on a rising edge when in_valid && in_ready. Writes in_data at wptr; wptr += 1.
- in_ready = (count != DEPTH). It is combinational from count only and never depends on in_valid or read_ext.
- Pop: occurs on a rising edge when read_ext && (count != 0); rptr += 1.
- read_ext while count == 0:
  - No pointer change.
  - underflow <= 1 on the same edge.
  - Holds until clear_error or reset.
- If clear_error and an underflow event occur on the same edge, set wins (underflow = 1).
- count update per edge: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Simultaneous push and pop:
  - Non-empty, non-full: both proceed; count unchanged.
  - Empty: push accepted, pop counts as underflow. Result: count = 1, underflow = 1, and the pushed word is at the head.
  - Full: in_ready = 0, so no push. The pop proceeds, count = DEPTH-1, and in_ready = 1 in the next cycle. There is no same-cycle full bypass.
- ext_out = storage[rptr] when count != 0, else all zeros. Combinational from registers; no latency beyond the storage register.
- Latency:
  - A word pushed at edge N is visible on ext_out and ext_available after edge N (zero extra cycles).
  - Pop at edge N presents the next word after edge N.
- ext_available = (count != 0).
- in_data and in_valid are sampled only when in_ready = 1. The producer must hold in_data/in_valid until accepted.
- Reset mid-operation discards all contents. A push or pop on the edge coincident with reset release is not required to be captured.

Test Plan:
- Reset then idle:
  - Hold rst_n = 0 for 2 cycles and release.
  - Required: count = 0, ext_available = 0, ext_out = 11'b00000000000, in_ready = 1, underflow = 0.
- Fill and order:
  - Push 11'b00001001001, 11'b11101001001, 11'b00001100100, 11'b00000000001 on consecutive cycles.
  - Required: in_ready = 0 with count = 4.
  - A 5th word with in_valid = 1 is not accepted.
  - Four read_ext pops return the words in the push order on ext_out.
  - Then ext_available = 0 and ext_out = 0.
- Wrap-around:
  - Push 3, pop 3, then push 4 words (pointers cross DEPTH).
  - Required: FIFO order is preserved and count reaches 4.
- Simultaneous push+pop:
  - With count = 2 and head = 11'b00001100100, assert in_valid and read_ext together for 3 cycles.
  - Required: count stays 2 and ext_out advances each cycle.
  - With count = 4 and both asserted, the pop only occurs: count = 3.
- Underflow:
  - read_ext with count = 0. Required: underflow = 1 and count stays 0.
  - Push and read_ext together when empty. Required: count = 1, underflow stays 1.
  - clear_error pulse. Required: underflow = 0 next cycle.
- Asynchronous reset mid-operation:
  - With count = 3, drive rst_n low between clock edges.
  - Required: count = 0, ext_available = 0, ext_out = 0 immediately, without waiting for a clock edge.
